// File: rtl/mmio_io_ctrl_if.sv
// CPU-side bus of the minisys memory/IO controller: access strobes, address,
// store data, Data_mem read data and the pass-through / write-back results.
interface mmio_io_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic              io_read;
    logic              io_write;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] m_rdata;
    logic [ADDR_W-1:0] addr_out;
    logic              mem_wen;
    logic [DATA_W-1:0] r_wdata;

    modport master (
        output mem_read, mem_write, io_read, io_write, addr_in, wdata, m_rdata,
        input  addr_out, mem_wen, r_wdata
    );

    modport slave (
        input  mem_read, mem_write, io_read, io_write, addr_in, wdata, m_rdata,
        output addr_out, mem_wen, r_wdata
    );
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped IO controller: LED/CTRL/SW/STATUS registers, debounced switches,
// LED blink prescaler and a sticky error for unmapped IO accesses.
module mmio_io_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(32'hFFFF_FC00),
    parameter int                LED_CH     = 2,
    parameter int                LED_W      = 16,
    parameter int                SW_CH      = 2,
    parameter int                SW_W       = 16,
    parameter int                DEB_CYCLES = 20000,
    parameter int                BLINK_DIV  = 2500000
) (
    input  logic                    clock,
    input  logic                    rst,
    mmio_io_ctrl_if.slave           bus,
    input  logic [SW_CH*SW_W-1:0]   switch_in,
    output logic [LED_CH*LED_W-1:0] led_out,
    output logic                    err
);
    localparam int               DEB_W      = $clog2(DEB_CYCLES);
    localparam int               BLK_W      = $clog2(BLINK_DIV);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_DIV - 1);
    localparam logic [9:0]       LED_OFF    = 10'h060;
    localparam logic [9:0]       SW_OFF     = 10'h070;
    localparam logic [9:0]       CTRL_OFF   = 10'h080;
    localparam logic [9:0]       STATUS_OFF = 10'h084;

    logic [LED_CH-1:0][LED_W-1:0] led_reg;
    logic [LED_CH-1:0]            ctrl_reg;
    logic [BLK_W-1:0]             prescaler;
    logic                         blink_phase;
    logic [SW_CH-1:0][SW_W-1:0]   sw_meta;
    logic [SW_CH-1:0][SW_W-1:0]   sw_sync;
    logic [SW_CH-1:0][SW_W-1:0]   sw_deb;
    logic [SW_CH-1:0][DEB_W-1:0]  deb_cnt;
    logic [SW_CH-1:0]             chg_flag;
    logic [SW_CH-1:0]             chg_evt;

    logic              io_hit;
    logic [9:0]        off;
    logic [LED_CH-1:0] led_sel;
    logic [SW_CH-1:0]  sw_sel;
    logic              ctrl_sel;
    logic              status_sel;
    logic              mapped;
    logic              writable;
    logic              wr_en;
    logic              err_set;
    logic              status_clr;
    logic [DATA_W-1:0] io_rdata;

    // Store-data bits above the widest register are intentionally ignored.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;

    assign bus.addr_out = bus.addr_in;
    assign bus.mem_wen  = bus.mem_write;

    assign io_hit     = bus.addr_in[ADDR_W-1:10] == IO_BASE[ADDR_W-1:10];
    assign off        = bus.addr_in[9:0];
    assign ctrl_sel   = off == CTRL_OFF;
    assign status_sel = off == STATUS_OFF;

    // NOTE: combinational blocks use blocking '=' and default every output first, so no latch is inferred.
    always_comb begin
        led_sel = '0;
        sw_sel  = '0;
        for (int i = 0; i < LED_CH; i++) led_sel[i] = off == LED_OFF + 10'(4 * i);
        for (int j = 0; j < SW_CH; j++)  sw_sel[j]  = off == SW_OFF + 10'(4 * j);
    end

    assign mapped   = (|led_sel) || (|sw_sel) || ctrl_sel || status_sel;
    assign writable = (|led_sel) || ctrl_sel;

    // A simultaneous read+write still performs the write but is flagged as an error.
    assign wr_en      = bus.io_write && io_hit && writable;
    assign err_set    = (bus.io_read || bus.io_write) &&
                        (!io_hit || !mapped || (bus.io_write && !writable) ||
                         (bus.io_read && bus.io_write));
    assign status_clr = bus.io_read && !bus.io_write && io_hit && status_sel;

    always_comb begin
        io_rdata = '0;
        for (int i = 0; i < LED_CH; i++) if (led_sel[i]) io_rdata = DATA_W'(led_reg[i]);
        for (int j = 0; j < SW_CH; j++)  if (sw_sel[j])  io_rdata = DATA_W'(sw_deb[j]);
        if (ctrl_sel) io_rdata = DATA_W'(ctrl_reg);
        if (status_sel) begin
            io_rdata             = DATA_W'(chg_flag);
            io_rdata[DATA_W-1]   = err;
        end
    end

    always_comb begin
        bus.r_wdata = '0;
        if (bus.mem_read)
            bus.r_wdata = bus.m_rdata;
        else if (bus.io_read && !bus.io_write && io_hit && mapped)
            bus.r_wdata = io_rdata;
    end

    // NOTE: the LED bank is a handful of flops, not a RAM, so it is reset with the rest of the state.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            led_reg  <= '0;
            ctrl_reg <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LED_CH; i++)
                if (led_sel[i]) led_reg[i] <= bus.wdata[LED_W-1:0];
            if (ctrl_sel) ctrl_reg <= bus.wdata[LED_CH-1:0];
        end
    end

    always_comb begin
        chg_evt = '0;
        for (int j = 0; j < SW_CH; j++)
            chg_evt[j] = (sw_sync[j] != sw_deb[j]) && (deb_cnt[j] == DEB_LAST);
    end

    // NOTE: state updates use '<=' so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_deb  <= '0;
            deb_cnt <= '0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
            for (int j = 0; j < SW_CH; j++) begin
                if (sw_sync[j] == sw_deb[j]) begin
                    deb_cnt[j] <= '0;
                end else if (chg_evt[j]) begin
                    sw_deb[j]  <= sw_sync[j];
                    deb_cnt[j] <= '0;
                end else begin
                    deb_cnt[j] <= deb_cnt[j] + DEB_W'(1);
                end
            end
        end
    end

    // A STATUS read clears, but a same-cycle event or error wins.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            chg_flag <= '0;
            err      <= 1'b0;
        end else begin
            chg_flag <= (status_clr ? '0 : chg_flag) | chg_evt;
            err      <= (err && !status_clr) || err_set;
        end
    end

    // Free-running prescaler; CTRL writes deliberately leave it alone.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            prescaler   <= '0;
            blink_phase <= 1'b0;
        end else if (prescaler == BLK_LAST) begin
            prescaler   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            prescaler <= prescaler + BLK_W'(1);
        end
    end

    always_comb begin
        led_out = '0;
        for (int i = 0; i < LED_CH; i++)
            led_out[i*LED_W +: LED_W] = led_reg[i] & ~{LED_W{ctrl_reg[i] & blink_phase}};
    end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_mmio_io_ctrl;
    localparam int SIG_RDATA = 0;
    localparam int SIG_LED   = 1;
    localparam int SIG_ERR   = 2;
    localparam int SIG_ADDR  = 3;
    localparam int SIG_WEN   = 4;

    localparam logic [31:0] A_LED0   = 32'hFFFF_FC60;
    localparam logic [31:0] A_LED1   = 32'hFFFF_FC64;
    localparam logic [31:0] A_SW0    = 32'hFFFF_FC70;
    localparam logic [31:0] A_SW1    = 32'hFFFF_FC74;
    localparam logic [31:0] A_CTRL   = 32'hFFFF_FC80;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FC84;
    localparam logic [31:0] A_BAD    = 32'hFFFF_FC90;

    logic        clock = 1'b0;
    logic        rst;
    logic [31:0] switch_in;
    logic [31:0] led_out;
    logic        err;

    mmio_io_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mmio_io_ctrl #(
        .DEB_CYCLES(4),
        .BLINK_DIV (8)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .bus      (bus),
        .switch_in(switch_in),
        .led_out  (led_out),
        .err      (err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    string       name_q[$];
    int          sig_q[$];
    logic [31:0] val_q[$];
    int          cyc_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic push_exp(input string name, input int sig, input logic [31:0] val);
        name_q.push_back(name);
        sig_q.push_back(sig);
        val_q.push_back(val);
        cyc_q.push_back(cyc);
    endtask

    string       m_name;
    int          m_sig;
    logic [31:0] m_val;
    int          m_cyc;
    logic [31:0] m_act;

    always @(negedge clock) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            m_name = name_q.pop_front();
            m_sig  = sig_q.pop_front();
            m_val  = val_q.pop_front();
            m_cyc  = cyc_q.pop_front();
            case (m_sig)
                SIG_RDATA: m_act = bus.r_wdata;
                SIG_LED:   m_act = led_out;
                SIG_ERR:   m_act = {31'b0, err};
                SIG_ADDR:  m_act = bus.addr_out;
                default:   m_act = {31'b0, bus.mem_wen};
            endcase
            n_vec++;
            if (m_cyc != cyc || m_act !== m_val) begin
                n_bad++;
                $display("FAIL %s (cycle %0d, queued %0d): got %08h, want %08h",
                         m_name, cyc, m_cyc, m_act, m_val);
            end
        end
    end

    task automatic idle();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.io_read   = 1'b0;
        bus.io_write  = 1'b0;
        bus.addr_in   = '0;
        bus.wdata     = '0;
        bus.m_rdata   = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic io_wr(input logic [31:0] addr, input logic [31:0] data);
        bus.io_write = 1'b1;
        bus.addr_in  = addr;
        bus.wdata    = data;
        step();
        idle();
    endtask

    task automatic io_rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.io_read = 1'b1;
        bus.addr_in = addr;
        push_exp(name, SIG_RDATA, exp);
        step();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want end of stimulus");
        $fatal(1, "watchdog expired");
    end

    int rel_cyc;
    int ph;

    initial begin
        rst       = 1'b1;
        switch_in = '0;
        idle();
        repeat (2) step();
        push_exp("reset_led", SIG_LED, 32'h0);
        push_exp("reset_err", SIG_ERR, 32'h0);
        step();
        rst = 1'b0;

        // Build up state, then reset mid-run.
        io_wr(A_LED0, 32'h0000_1234);
        io_wr(A_BAD, 32'h0);
        push_exp("pre_reset_led", SIG_LED, 32'h0000_1234);
        push_exp("pre_reset_err", SIG_ERR, 32'h1);
        step();
        rst = 1'b1;
        push_exp("midrun_reset_led", SIG_LED, 32'h0);
        push_exp("midrun_reset_err", SIG_ERR, 32'h0);
        step();
        rst     = 1'b0;
        rel_cyc = cyc;
        io_rd("status_after_reset", A_STATUS, 32'h0);

        // LED write and readback.
        io_wr(A_LED1, 32'h0000_A5A5);
        push_exp("led1_drive", SIG_LED, 32'hA5A5_0000);
        io_rd("led1_readback", A_LED1, 32'h0000_A5A5);
        push_exp("led_write_no_err", SIG_ERR, 32'h0);
        io_wr(A_CTRL, 32'hFFFF_FFFF);
        io_rd("ctrl_masked", A_CTRL, 32'h0000_0003);
        io_wr(A_CTRL, 32'h0);

        // Debounce: accepted exactly 2 + DEB_CYCLES edges after the change.
        switch_in = 32'h0000_00FF;
        repeat (5) step();
        io_rd("sw0_before_accept", A_SW0, 32'h0);
        io_rd("sw0_accepted", A_SW0, 32'h0000_00FF);
        io_rd("sw1_idle", A_SW1, 32'h0);
        io_rd("status_flag_set", A_STATUS, 32'h0000_0001);
        io_rd("status_flag_cleared", A_STATUS, 32'h0);

        // A 3-cycle glitch must be rejected.
        switch_in = 32'h0000_0F00;
        repeat (3) step();
        switch_in = 32'h0000_00FF;
        repeat (6) step();
        io_rd("sw0_glitch_rejected", A_SW0, 32'h0000_00FF);
        io_rd("status_no_glitch_flag", A_STATUS, 32'h0);

        // Blink: phase flips every 8 cycles from reset release.
        io_wr(A_LED0, 32'h0000_FFFF);
        io_wr(A_CTRL, 32'h0000_0001);
        for (int k = 0; k < 16; k++) begin
            ph = ((cyc - rel_cyc) / 8) % 2;
            push_exp("blink_led", SIG_LED, (ph != 0) ? 32'hA5A5_0000 : 32'hA5A5_FFFF);
            step();
        end
        io_wr(A_CTRL, 32'h0);
        for (int k = 0; k < 10; k++) begin
            push_exp("blink_off_led", SIG_LED, 32'hA5A5_FFFF);
            step();
        end

        // Unmapped write and read-to-clear.
        io_wr(A_BAD, 32'h1);
        push_exp("unmapped_write_err", SIG_ERR, 32'h1);
        io_rd("status_err_bit", A_STATUS, 32'h8000_0000);
        push_exp("err_cleared", SIG_ERR, 32'h0);

        // Read-to-clear colliding with a switch change event on the same edge.
        switch_in = 32'h0000_0001;
        io_wr(A_BAD, 32'h1);
        repeat (4) step();
        io_rd("status_err_collide", A_STATUS, 32'h8000_0000);
        push_exp("err_cleared_collide", SIG_ERR, 32'h0);
        io_rd("status_flag_survives", A_STATUS, 32'h0000_0001);
        io_rd("status_after_collide", A_STATUS, 32'h0);
        io_rd("sw0_new_value", A_SW0, 32'h0000_0001);

        // Writes to read-only registers are errors with no effect.
        io_wr(A_SW0, 32'h5);
        push_exp("sw_write_err", SIG_ERR, 32'h1);
        io_rd("sw0_unchanged", A_SW0, 32'h0000_0001);
        io_rd("status_after_sw_write", A_STATUS, 32'h8000_0000);

        // Simultaneous read and write: write lands, read returns 0, err set.
        bus.io_read  = 1'b1;
        bus.io_write = 1'b1;
        bus.addr_in  = A_LED0;
        bus.wdata    = 32'h0000_0F0F;
        push_exp("rdwr_rdata", SIG_RDATA, 32'h0);
        step();
        idle();
        push_exp("rdwr_led", SIG_LED, 32'hA5A5_0F0F);
        push_exp("rdwr_err", SIG_ERR, 32'h1);
        io_rd("status_after_rdwr", A_STATUS, 32'h8000_0000);

        // IO read outside the IO region.
        io_rd("miss_read_rdata", 32'h0000_0060, 32'h0);
        push_exp("miss_read_err", SIG_ERR, 32'h1);
        io_rd("unmapped_off_rdata", 32'hFFFF_FC68, 32'h0);
        io_rd("status_after_miss", A_STATUS, 32'h8000_0000);

        // Memory pass-through.
        bus.mem_read = 1'b1;
        bus.addr_in  = 32'h0000_0100;
        bus.m_rdata  = 32'h1234_5678;
        push_exp("mem_read_rdata", SIG_RDATA, 32'h1234_5678);
        push_exp("mem_read_addr", SIG_ADDR, 32'h0000_0100);
        push_exp("mem_read_wen", SIG_WEN, 32'h0);
        step();
        idle();
        bus.mem_write = 1'b1;
        bus.addr_in   = A_LED1;
        bus.wdata     = 32'h0000_DEAD;
        push_exp("mem_write_wen", SIG_WEN, 32'h1);
        push_exp("mem_write_addr", SIG_ADDR, A_LED1);
        push_exp("mem_write_rdata", SIG_RDATA, 32'h0);
        step();
        idle();
        push_exp("mem_write_led_same", SIG_LED, 32'hA5A5_0F0F);
        push_exp("mem_write_no_err", SIG_ERR, 32'h0);

        repeat (2) step();
        n_vec++;
        if (cyc_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drained: got %0d pending, want 0", cyc_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
